// File: rtl/mix_typewriter_out.sv
// MIX OUT block engine for the typewriter: accepts BLOCK_WORDS words and
// streams each as five 6-bit character codes, byte 1 first, over a valid/ready link.
module mix_typewriter_out #(
  parameter int BLOCK_WORDS = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        word_valid,
  input  logic [30:0] word_in,
  output logic        word_ready,
  output logic        busy,
  output logic        char_valid,
  output logic [5:0]  char_out,
  output logic        char_last,
  input  logic        char_ready
);

  localparam int WCW = $clog2(BLOCK_WORDS + 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    EMIT      = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [29:0]     buf_q, buf_d;
  logic [2:0]      char_cnt_q, char_cnt_d;
  logic [WCW-1:0]  word_cnt_q, word_cnt_d;
  logic            xfer;

  // The sign travels with the word but has no printable character.
  logic            unused_sign;
  assign unused_sign = word_in[30];

  assign xfer = (state_q == EMIT) && char_ready;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    char_cnt_d = char_cnt_q;
    word_cnt_d = word_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WAIT_WORD;
          char_cnt_d = '0;
          word_cnt_d = '0;
        end
      end
      WAIT_WORD: begin
        if (word_valid) begin
          buf_d   = word_in[29:0];
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (xfer) begin
          buf_d = {buf_q[23:0], 6'd0};
          if (char_cnt_q == 3'd4) begin
            char_cnt_d = '0;
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = (word_cnt_q == LAST_WORD) ? IDLE : WAIT_WORD;
          end else begin
            char_cnt_d = char_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      char_cnt_q <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      char_cnt_q <= char_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Outputs are pure functions of registered state, so they never glitch with inputs.
  assign busy       = (state_q != IDLE);
  assign word_ready = (state_q == WAIT_WORD);
  assign char_valid = (state_q == EMIT);
  assign char_out   = buf_q[29:24];
  assign char_last  = (state_q == EMIT) && (char_cnt_q == 3'd4) && (word_cnt_q == LAST_WORD);

endmodule

// File: tb/tb_mix_typewriter_out.sv
// Randomized bench for mix_typewriter_out: a queue-based block model checked every
// cycle, plus directed literal checks on a 14-word and a 1-word instance.
module tb_mix_typewriter_out;

  localparam int BW = 14;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 14-word instance
  logic        rst, start, wv, cr;
  logic [30:0] win;
  logic        o_wr, o_busy, o_cv, o_cl;
  logic [5:0]  o_co;

  // 1-word instance
  logic        rst1, start1, wv1, cr1;
  logic [30:0] win1;
  logic        o1_wr, o1_busy, o1_cv, o1_cl;
  logic [5:0]  o1_co;

  mix_typewriter_out #(.BLOCK_WORDS(BW)) u_dut (
    .clk(clk), .reset(rst), .start(start), .word_valid(wv), .word_in(win),
    .word_ready(o_wr), .busy(o_busy), .char_valid(o_cv), .char_out(o_co),
    .char_last(o_cl), .char_ready(cr));

  mix_typewriter_out #(.BLOCK_WORDS(1)) u_dut1 (
    .clk(clk), .reset(rst1), .start(start1), .word_valid(wv1), .word_in(win1),
    .word_ready(o1_wr), .busy(o1_busy), .char_valid(o1_cv), .char_out(o1_co),
    .char_last(o1_cl), .char_ready(cr1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a block is active between start and its last character;
  // while active, either no word is pending (ready for one) or its remaining chars queue up.
  bit         m_active = 1'b0;
  int         m_words  = 0;
  logic [5:0] mq[$];

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_words  = 0;
      mq.delete();
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_words  = 0;
      end
    end else if (mq.size() == 0) begin
      if (wv) begin
        for (int k = 0; k < 5; k++) mq.push_back(win[29 - 6*k -: 6]);
        m_words++;
      end
    end else if (cr) begin
      void'(mq.pop_front());
      if (mq.size() == 0 && m_words == BW) m_active = 1'b0;
    end
  end

  // DUT-side transfer monitor
  logic [5:0] cap[$];
  int         lasts   = 0;
  int         accepts = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (o_cv && cr) begin
        cap.push_back(o_co);
        if (o_cl) lasts++;
      end
      if (o_wr && wv) accepts++;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy",       32'(o_busy), 32'(m_active));
    chk("word_ready", 32'(o_wr),   32'(m_active && mq.size() == 0));
    chk("char_valid", 32'(o_cv),   32'(mq.size() != 0));
    chk("char_out",   32'(o_co),   (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk("char_last",  32'(o_cl),   32'(mq.size() == 1 && m_words == BW));
  end

  // mode 0: directed words + stall on char 2; 1: random; 2: reset after 7 chars
  task automatic run_block(input int mode);
    int base, l0, a0, stall, cyc;
    bit aborted;
    base = cap.size(); l0 = lasts; a0 = accepts; stall = 0; aborted = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (m_active && cyc < 3000) begin
      cyc++;
      if (mode == 0) begin
        wv = 1'b1;
        if (m_words == 0)      win = 31'h0108_3105;
        else if (m_words == 1) win = 31'h7F00_003F;
        else                   win = 31'($urandom);
        if (cap.size() == base + 1 && stall < 3) begin
          chk("stall_char2", 32'(o_co), 32'd2);
          cr = 1'b0;
          stall++;
        end else begin
          cr = 1'b1;
        end
      end else if (mode == 1) begin
        wv    = 1'($urandom_range(0, 1));
        win   = 31'($urandom);
        cr    = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 7) == 0);
      end else begin
        wv  = 1'b1;
        win = 31'($urandom);
        cr  = 1'b1;
        if (cap.size() - base == 7) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk("abort_busy",  32'(o_busy), 32'd0);
          chk("abort_valid", 32'(o_cv),   32'd0);
          aborted = 1'b1;
          break;
        end
      end
      @(negedge clk);
    end
    start = 1'b0; wv = 1'b0; cr = 1'b0;
    if (cyc >= 3000) chk("block_timeout", 32'd1, 32'd0);
    if (mode == 2) begin
      chk("abort_seen",  32'(aborted), 32'd1);
      chk("abort_chars", 32'(cap.size() - base), 32'd7);
    end else begin
      chk("block_chars",   32'(cap.size() - base), 32'(5 * BW));
      chk("block_lasts",   32'(lasts - l0),        32'd1);
      chk("block_accepts", 32'(accepts - a0),      32'(BW));
    end
    if (mode == 0) begin
      logic [5:0] exp10 [10];
      exp10 = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd63, 6'd0, 6'd0, 6'd0, 6'd63};
      for (int i = 0; i < 10; i++) chk("directed_seq", 32'(cap[base + i]), 32'(exp10[i]));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wv = 1'b0; cr = 1'b0; win = '0;
    rst1 = 1'b1; start1 = 1'b0; wv1 = 1'b0; cr1 = 1'b0; win1 = '0;
    repeat (3) @(negedge clk);

    // Single-word block on the BLOCK_WORDS=1 instance
    chk("bw1_reset_busy", 32'(o1_busy), 32'd0);
    chk("bw1_reset_char", 32'(o1_co),   32'd0);
    rst1 = 1'b0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("bw1_busy_rise", 32'(o1_busy), 32'd1);
    chk("bw1_word_rdy",  32'(o1_wr),   32'd1);
    wv1 = 1'b1; win1 = 31'h0108_3105; cr1 = 1'b1;
    @(negedge clk);
    wv1 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk("bw1_valid", 32'(o1_cv), 32'd1);
      chk("bw1_char",  32'(o1_co), 32'(i));
      chk("bw1_last",  32'(o1_cl), 32'(i == 5));
      @(negedge clk);
    end
    chk("bw1_busy_fall", 32'(o1_busy), 32'd0);
    chk("bw1_valid_off", 32'(o1_cv),   32'd0);
    cr1 = 1'b0;

    // 14-word instance: reset state, then stray word_valid in IDLE
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_char", 32'(o_co),   32'd0);
    rst = 1'b0;
    wv = 1'b1; win = 31'($urandom);
    repeat (2) @(negedge clk);
    wv = 1'b0;
    chk("idle_word_ignored", 32'(o_busy), 32'd0);

    run_block(0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      run_block(1);
    end
    @(negedge clk);
    run_block(2);
    @(negedge clk);
    run_block(1);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
